// File: rtl/cipher_tx_serializer.sv
// cipher_tx_serializer: queues 128-bit cipher results in a small block FIFO
// and streams each block to uart_tx as 16 bytes, most significant byte first,
// using the tx_en / tx_busy handshake.
module cipher_tx_serializer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blk_valid,
  input  logic [127:0]     blk_data,
  input  logic             tx_busy,
  output logic             tx_en,
  output logic [7:0]       tx_data,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic             idle
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t           state_q;
  logic [127:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             overflow_q;
  logic             tx_en_q;
  logic [7:0]       tx_data_q;
  logic [127:0]     shreg_q;
  logic [4:0]       byte_cnt_q;

  logic pop;
  logic full;
  logic push;

  // The head is consumed only while loading; a full FIFO still takes a new
  // block in that cycle because the slot is freed at the same edge.
  assign pop  = (state_q == S_LOAD);
  assign full = (count_q == CNT_W'(DEPTH));
  assign push = blk_valid && (!full || pop);

  // Occupancy next-state: simultaneous push and pop cancel out
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO control: pointers (wrap naturally at power-of-2 depth), count, sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (blk_valid && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= blk_data;
    end
  end

  // Byte shift register: loaded from the FIFO head, shifted as each byte issues
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) begin
      shreg_q <= mem_q[rd_ptr_q];
    end else if (state_q == S_SEND && !tx_busy) begin
      shreg_q <= {shreg_q[119:0], 8'h00};
    end
  end

  // Transmit FSM with registered tx_en / tx_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_en_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      byte_cnt_q <= 5'd0;
    end else begin
      tx_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          byte_cnt_q <= 5'd0;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_en_q    <= 1'b1;
            tx_data_q  <= shreg_q[127:120];
            byte_cnt_q <= byte_cnt_q + 5'd1;
            state_q    <= S_HOLD;
          end
        end
        S_HOLD: begin
          // busy from uart_tx may only rise now, so it is not sampled here
          if (byte_cnt_q == 5'd16) begin
            state_q <= (count_q != '0) ? S_LOAD : S_IDLE;
          end else begin
            state_q <= S_SEND;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign idle       = (state_q == S_IDLE) && (count_q == '0);

endmodule

// File: tb/tb_cipher_tx_serializer.sv
// Scoreboard bench for cipher_tx_serializer: stimulus pushes expected bytes
// into a queue, a forked monitor pops and compares on every tx_en.
module tb_cipher_tx_serializer;

  logic         clk;
  logic         rst_n;
  logic         blk_valid;
  logic [127:0] blk_data;
  logic         tx_busy;
  logic         tx_en;
  logic [7:0]   tx_data;
  logic [2:0]   fifo_count;
  logic         overflow;
  logic         idle;

  logic busy_force;
  logic model_busy;
  bit   busy_mode;

  assign tx_busy = busy_force | model_busy;

  cipher_tx_serializer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data),
    .tx_busy    (tx_busy),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  localparam logic [127:0] BLK_T1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_T2 = 128'h5A01_5A02_5A03_5A04_5A05_5A06_5A07_5A08;
  localparam logic [127:0] BLK_A  = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
  localparam logic [127:0] BLK_B  = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
  localparam logic [127:0] BLK_C  = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
  localparam logic [127:0] BLK_W  = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

  int          n_cmp;
  int          n_bad;
  int          pulse_cnt;
  int          peak_cnt;
  logic [7:0]  exp_q [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected bytes of a block, most significant first
  task automatic expect_blk(input logic [127:0] d);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(d[127-8*k -: 8]);
    end
  endtask

  task automatic push_blk(input logic [127:0] d);
    blk_data  = d;
    blk_valid = 1'b1;
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string name);
    int cnt;
    cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (tx_en) cnt++;
      if (cnt == n) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout, saw %0d tx_en pulses, expected %0d", name, cnt, n);
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && idle) break;
    end
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_idle"}, idle, 1'b1);
  endtask

  // Scoreboard monitor: checks byte value/order and the handshake rules
  task automatic monitor();
    logic [7:0] e;
    bit prev_en;
    bit prev_busy;
    prev_en   = 0;
    prev_busy = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en   = 0;
        prev_busy = 0;
      end else begin
        peak_cnt = (int'(fifo_count) > peak_cnt) ? int'(fifo_count) : peak_cnt;
        if (tx_en) begin
          pulse_cnt++;
          n_cmp++;
          if (prev_en) begin
            n_bad++;
            $display("FAIL tx_en_adjacent: got 1 in consecutive cycles, required 0");
          end
          n_cmp++;
          if (prev_busy) begin
            n_bad++;
            $display("FAIL tx_en_while_busy: tx_en issued with tx_busy=1, required tx_busy=0");
          end
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_byte: got %02h, no byte expected", tx_data);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e) begin
              n_bad++;
              $display("FAIL byte_order: got %02h, expected %02h", tx_data, e);
            end
          end
        end
        prev_en   = tx_en;
        prev_busy = tx_busy;
      end
    end
  endtask

  // uart_tx model: busy rises one cycle after tx_en and stays for 10 cycles
  task automatic busy_model();
    forever begin
      @(posedge clk);
      #1;
      if (busy_mode && tx_en) begin
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  endtask

  initial begin
    int lat;
    n_cmp      = 0;
    n_bad      = 0;
    pulse_cnt  = 0;
    peak_cnt   = 0;
    rst_n      = 1'b0;
    blk_valid  = 1'b0;
    blk_data   = '0;
    busy_force = 1'b0;
    model_busy = 1'b0;
    busy_mode  = 0;
    fork
      monitor();
      busy_model();
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_en", tx_en, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_idle", idle, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: latency and byte order, uart never busy
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back({k[3:0], k[3:0]});
    end
    push_blk(BLK_T1);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (tx_en) begin
        lat = k;
        break;
      end
    end
    chk("t1_latency", lat, 3);
    wait_drain("t1");

    // 2: busy for 10 cycles per byte, raised late
    busy_mode = 1;
    pulse_cnt = 0;
    expect_blk(BLK_T2);
    push_blk(BLK_T2);
    wait_drain("t2");
    chk("t2_pulses", pulse_cnt, 16);
    busy_mode = 0;
    repeat (15) @(posedge clk);
    #1;

    // 3: three blocks on consecutive cycles
    pulse_cnt = 0;
    peak_cnt  = 0;
    expect_blk(BLK_A);
    expect_blk(BLK_B);
    expect_blk(BLK_C);
    push_blk(BLK_A);
    push_blk(BLK_B);
    push_blk(BLK_C);
    wait_drain("t3");
    chk("t3_peak", peak_cnt, 2);
    chk("t3_pulses", pulse_cnt, 48);
    chk("t3_overflow", overflow, 1'b0);

    // 4: busy stuck, six blocks offered: one in flight, four queued, one dropped
    pulse_cnt  = 0;
    busy_force = 1'b1;
    expect_blk(BLK_A);
    push_blk(BLK_A);
    repeat (4) @(posedge clk);
    #1;
    expect_blk(BLK_B);
    push_blk(BLK_B);
    expect_blk(BLK_C);
    push_blk(BLK_C);
    expect_blk(BLK_T1);
    push_blk(BLK_T1);
    expect_blk(BLK_T2);
    push_blk(BLK_T2);
    push_blk(BLK_W);
    chk("t4_count_full", fifo_count, 3'd4);
    chk("t4_overflow", overflow, 1'b1);
    busy_force = 1'b0;

    // 5: push lands exactly on the S_LOAD pop while the FIFO is full
    wait_tx(16, "t5_inflight");
    @(posedge clk);
    #1;
    expect_blk(~BLK_W);
    push_blk(~BLK_W);
    chk("t5_count", fifo_count, 3'd4);
    chk("t5_overflow", overflow, 1'b1);
    wait_drain("t4");
    chk("t4_pulses", pulse_cnt, 96);

    // 6: reset mid-block with two queued, then a clean block
    expect_blk(BLK_A);
    expect_blk(BLK_B);
    expect_blk(BLK_C);
    push_blk(BLK_A);
    push_blk(BLK_B);
    push_blk(BLK_C);
    chk("t6_queued", fifo_count, 3'd2);
    wait_tx(7, "t6_partial");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_tx_en", tx_en, 1'b0);
    chk("t6_count", fifo_count, 3'd0);
    chk("t6_idle", idle, 1'b1);
    chk("t6_overflow", overflow, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    pulse_cnt = 0;
    expect_blk(BLK_W);
    push_blk(BLK_W);
    wait_drain("t6");
    chk("t6_pulses", pulse_cnt, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
